// File: rtl/aes_key_mem128.sv
// -----------------------------------------------------------------------------
// aes_key_mem128
// AES-128 key expansion and round-key store. A 128-bit cipher key is sampled
// on an init pulse and expanded one round key per clock into an 11-entry
// register file. Once all entries are valid, ready goes high. Round keys are
// then read combinationally by round index.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   init       in   1    start pulse; key sampled on the same edge
//   key        in   128  cipher key, byte 0 in bits [127:120]
//   round      in   4    round index 0..10 (11..15 read as zero)
//   round_key  out  128  combinational read of entry[round]
//   ready      out  1    all 11 entries valid
// -----------------------------------------------------------------------------
module aes_key_mem128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] bit_idx;
        bit_idx = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[bit_idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        state_r;
    state_t        next_state_s;
    logic [127:0]  entry_r [0:10];
    logic [127:0]  w_r;
    logic [3:0]    rcnt_r;
    logic [7:0]    rcon_r;
    logic          ready_r;

    logic [31:0]   t_s;
    logic [31:0]   wn0_s;
    logic [31:0]   wn1_s;
    logic [31:0]   wn2_s;
    logic [31:0]   wn3_s;
    logic [127:0]  round_key_s;

    // One key-schedule round: RotWord/SubWord/Rcon on w3, then the XOR chain.
    always_comb begin
        t_s   = sub_word({w_r[23:0], w_r[31:24]}) ^ {rcon_r, 24'h000000};
        wn0_s = w_r[127:96] ^ t_s;
        wn1_s = w_r[95:64]  ^ wn0_s;
        wn2_s = w_r[63:32]  ^ wn1_s;
        wn3_s = w_r[31:0]   ^ wn2_s;
    end

    // Next-state logic; init restarts expansion from any state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                next_state_s = ST_IDLE;
            end
            ST_EXPAND: begin
                if (rcnt_r == 4'd10) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_EXPAND;
                end
            end
            ST_DONE: begin
                next_state_s = ST_DONE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        if (init) begin
            next_state_s = ST_EXPAND;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Ready flag: rises on the edge that writes entry 10, drops on init.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_DONE);
        end
    end

    // Working words, round counter and round constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_r    <= 128'h0;
            rcnt_r <= 4'd0;
            rcon_r <= 8'h01;
        end else if (init) begin
            w_r    <= key;
            rcnt_r <= 4'd1;
            rcon_r <= 8'h01;
        end else if (state_r == ST_EXPAND) begin
            w_r    <= {wn0_s, wn1_s, wn2_s, wn3_s};
            rcnt_r <= rcnt_r + 4'd1;
            rcon_r <= xtime(rcon_r);
        end else begin
            w_r    <= w_r;
            rcnt_r <= rcnt_r;
            rcon_r <= rcon_r;
        end
    end

    // Round-key store: entry 0 is the key, entries 1..10 written during expansion.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                entry_r[i] <= 128'h0;
            end
        end else if (init) begin
            entry_r[0] <= key;
        end else if (state_r == ST_EXPAND) begin
            entry_r[rcnt_r] <= {wn0_s, wn1_s, wn2_s, wn3_s};
        end else begin
            entry_r[0] <= entry_r[0];
        end
    end

    // Zero-latency read; indices past the last round read as zero.
    always_comb begin
        round_key_s = 128'h0;
        if (round <= 4'd10) begin
            round_key_s = entry_r[round];
        end else begin
            round_key_s = 128'h0;
        end
    end

    assign round_key = round_key_s;
    assign ready     = ready_r;

endmodule

// File: doc/aes_key_mem128.md
# aes_key_mem128

AES-128 key expansion and round-key store that sits directly upstream of `AES_encipher`. It accepts a 128-bit cipher key and expands it iteratively, one round key per cycle, into an 11-entry register file. When expansion is done it raises `ready`. It then serves `round_key` combinationally, indexed by the `round` value that the encipher drives. This replaces the precomputed round-key file the encipher bench uses today.

## Interface
- Parameters: none (AES-128 only; Nr = 10 fixed).
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `init`  in  1  — single-cycle start pulse; `key` is sampled on the same edge.
- `key`  in  128  — cipher key, byte 0 in bits [127:120].
- `round`  in  4  — round index from `AES_encipher` (0..10).
- `round_key`  out  128  — combinational read of entry `round` of the store.
- `ready`  out  1  — high when all 11 entries are valid.

## Operation
- State machine: IDLE, EXPAND, DONE.
- Reset:
  - All 11 entries cleared to 0.
  - `rcnt` = 0, `rcon` = 8'h01, state = IDLE, `ready` = 0.
  - `round_key` therefore reads 0.
- `init` sampled high, in any state:
  - entry[0] <= `key`; working words w0..w3 <= `key`.
  - `rcnt` <= 1; `rcon` <= 8'h01; `ready` <= 0; state <= EXPAND.
- EXPAND, each cycle:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - entry[rcnt] <= {w0',w1',w2',w3'}; w <= w'.
  - `rcnt` <= `rcnt`+1; `rcon` <= xtime(`rcon`), where xtime reduces modulo 0x11b.
  - Resulting `rcon` sequence: 01,02,04,08,10,20,40,80,1b,36.
- EXPAND exit: on the edge that writes entry[10], state <= DONE and `ready` <= 1.
- DONE: holds. Entries are stable until the next `init` or `rst`.
- SubWord: four parallel instances of the internal 256-entry S-box function, purely combinational.
- `round_key` read:
  - `round` 0..10 returns entry[`round`].
  - `round` 11..15 returns 128'h0.
  - Reads during EXPAND return current contents (may be stale or partial). The consumer must wait for `ready`.
- Boundary conditions:
  - `init` during EXPAND aborts and restarts with the new key. `ready` stays 0.
  - `init` during DONE drops `ready` on that edge.
  - `rst` and `init` high together: reset wins.
  - `rst` mid-expansion: clears everything; no partial entries remain.

## Timing
- Edge E0 samples `init`. Entries 1..10 are written on E1..E10. `ready` is high after E10.
- Latency from `init` to `ready`: 10 cycles after the sampling edge.
- Throughput: one key per 11 cycles. A back-to-back `init` at E11 is legal.
- Read path is zero-latency combinational. `round` may change every cycle.
- The encipher may assert `next` only once `ready` is high.

## Test plan
- Reset, then release with no `init` -> `ready` = 0; `round_key` = 0 for every `round` 0..15.
- `init` with `key` = 2b7e151628aed2a6abf7158809cf4f3c -> `ready` rises exactly 10 cycles later, and:
  - `round` 1 -> a0fafe1788542cb123a339392a6c7605.
  - `round` 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `round` 0 -> the key itself.
- `init` with all-zero key ->
  - `round` 1 -> 62636363626363636263636362636363.
  - `round` 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
  - `round` 12 -> 0.
- Zero-key `init`, then at cycle 5 `init` with the FIPS key -> `ready` rises 10 cycles after the second `init`, and all entries match the FIPS key schedule.
- `rst` asserted at cycle 6 of an expansion -> the next cycle shows `ready` = 0 and all entries 0. A subsequent `init` completes normally.
- Chained run: drive this block into `AES_encipher` for 100 random keys and blocks. Ciphertext must match the golden file with 0 errors.
